// File: rtl/udma_filter_rx_datastore.sv
// Write-side datastore for the uDMA filter: takes a processed beat stream and
// issues L2 writes on a uDMA RX channel with linear/sliding/circular/2D addressing.
module udma_filter_rx_datastore #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned L2_AWIDTH_NOAL = 15,
    parameter int unsigned TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     stream_data_i,
    input  logic                      stream_valid_i,
    output logic                      stream_ready_o,
    output logic                      rx_ch_valid_o,
    output logic [L2_AWIDTH_NOAL-1:0] rx_ch_addr_o,
    output logic [1:0]                rx_ch_datasize_o,
    output logic [DATA_WIDTH-1:0]     rx_ch_data_o,
    input  logic                      rx_ch_ready_i,
    input  logic                      cmd_start_i,
    output logic                      cmd_done_o,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i
);

    localparam int unsigned AW = L2_AWIDTH_NOAL;
    localparam int unsigned TW = TRANS_SIZE;
    localparam int unsigned DW = DATA_WIDTH;

    localparam logic [1:0] MODE_LINEAR   = 2'd0;
    localparam logic [1:0] MODE_SLIDING  = 2'd1;
    localparam logic [1:0] MODE_CIRCULAR = 2'd2;
    localparam logic [1:0] MODE_2D       = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t         state_q, state_d;

    logic [1:0]     mode_q;
    logic [1:0]     dsize_q;
    logic [TW-1:0]  len0_q, len1_q, len2_q;
    logic [AW-1:0]  startaddr_q, startaddr_d;
    logic [AW-1:0]  pointer_q, pointer_d;
    logic [TW-1:0]  w_q, w_d;
    logic [TW-1:0]  l_q, l_d;

    logic           valid_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  data_q;
    logic [1:0]     dsize_out_q;
    logic           done_q;

    logic           start_c;
    logic           ready_c;
    logic           capture_c;
    logic           rx_hs_c;
    logic           line_end_c;
    logic           last_c;
    logic [AW-1:0]  inc_c;

    assign start_c    = (state_q == ST_IDLE) && cmd_start_i;
    assign ready_c    = (state_q == ST_RUNNING) && (!valid_q || rx_ch_ready_i);
    assign capture_c  = stream_valid_i && ready_c;
    assign rx_hs_c    = valid_q && rx_ch_ready_i;
    assign line_end_c = (w_q == len0_q);
    assign last_c     = (mode_q == MODE_LINEAR) ? line_end_c
                                                : (line_end_c && (l_q == len1_q));

    // Element size to byte increment; the reserved encoding walks nowhere.
    always_comb begin
        inc_c = '0;
        case (dsize_q)
            2'b00:   inc_c = AW'(1);
            2'b01:   inc_c = AW'(2);
            2'b10:   inc_c = AW'(4);
            default: inc_c = '0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_start_i)         state_d = ST_RUNNING;
            ST_RUNNING: if (capture_c && last_c) state_d = ST_DRAIN;
            ST_DRAIN:   if (rx_hs_c)             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Address generator: advances once per captured beat
    always_comb begin
        startaddr_d = startaddr_q;
        pointer_d   = pointer_q;
        w_d         = w_q;
        l_d         = l_q;
        if (start_c) begin
            startaddr_d = cfg_start_addr_i;
            pointer_d   = cfg_start_addr_i;
            w_d         = '0;
            l_d         = '0;
        end else if (capture_c) begin
            if ((mode_q == MODE_LINEAR) || !line_end_c) begin
                pointer_d = pointer_q + inc_c;
                w_d       = w_q + TW'(1);
            end else begin
                w_d = '0;
                l_d = l_q + TW'(1);
                case (mode_q)
                    MODE_SLIDING: begin
                        startaddr_d = startaddr_q + inc_c;
                        pointer_d   = startaddr_q + inc_c;
                    end
                    MODE_CIRCULAR: begin
                        pointer_d = startaddr_q;
                    end
                    MODE_2D: begin
                        startaddr_d = startaddr_q + AW'(len2_q);
                        pointer_d   = startaddr_q + AW'(len2_q);
                    end
                    default: begin
                        pointer_d = pointer_q + inc_c;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration latch, address state and the single-entry output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q      <= '0;
            dsize_q     <= '0;
            len0_q      <= '0;
            len1_q      <= '0;
            len2_q      <= '0;
            startaddr_q <= '0;
            pointer_q   <= '0;
            w_q         <= '0;
            l_q         <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            dsize_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            if (start_c) begin
                mode_q  <= cfg_mode_i;
                dsize_q <= cfg_datasize_i;
                len0_q  <= cfg_len0_i;
                len1_q  <= cfg_len1_i;
                len2_q  <= cfg_len2_i;
            end
            startaddr_q <= startaddr_d;
            pointer_q   <= pointer_d;
            w_q         <= w_d;
            l_q         <= l_d;

            if (capture_c) begin
                valid_q     <= 1'b1;
                addr_q      <= pointer_q;
                data_q      <= stream_data_i;
                dsize_out_q <= dsize_q;
            end else if (rx_hs_c) begin
                valid_q <= 1'b0;
            end

            done_q <= (state_q == ST_DRAIN) && rx_hs_c;
        end
    end

    assign stream_ready_o   = ready_c;
    assign rx_ch_valid_o    = valid_q;
    assign rx_ch_addr_o     = addr_q;
    assign rx_ch_data_o     = data_q;
    assign rx_ch_datasize_o = dsize_out_q;
    assign cmd_done_o       = done_q;

endmodule

// File: tb/tb_udma_filter_rx_datastore.sv
// Directed bench for udma_filter_rx_datastore: addressing modes, backpressure,
// address wrap and reset mid-transfer, checked against hand-computed addresses.
module tb_udma_filter_rx_datastore;

    logic        clk;
    logic        rst_i;
    logic [31:0] stream_data;
    logic        stream_valid;
    logic        stream_ready;
    logic        rx_valid;
    logic [14:0] rx_addr;
    logic [1:0]  rx_dsize;
    logic [31:0] rx_data;
    logic        rx_ready;
    logic        cmd_start;
    logic        cmd_done;
    logic [14:0] cfg_start_addr;
    logic [1:0]  cfg_datasize;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_len0;
    logic [15:0] cfg_len1;
    logic [15:0] cfg_len2;

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q[$];

    udma_filter_rx_datastore #(
        .DATA_WIDTH(32), .L2_AWIDTH_NOAL(15), .TRANS_SIZE(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .stream_data_i(stream_data), .stream_valid_i(stream_valid),
        .stream_ready_o(stream_ready),
        .rx_ch_valid_o(rx_valid), .rx_ch_addr_o(rx_addr),
        .rx_ch_datasize_o(rx_dsize), .rx_ch_data_o(rx_data),
        .rx_ch_ready_i(rx_ready),
        .cmd_start_i(cmd_start), .cmd_done_o(cmd_done),
        .cfg_start_addr_i(cfg_start_addr), .cfg_datasize_i(cfg_datasize),
        .cfg_mode_i(cfg_mode), .cfg_len0_i(cfg_len0),
        .cfg_len1_i(cfg_len1), .cfg_len2_i(cfg_len2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Runs one transfer; addresses expected in exp_q, data beat k = dbase + k.
    task automatic run_xfer(input string name, input logic [1:0] mode, input logic [1:0] ds,
                            input logic [14:0] sa, input logic [15:0] l0, input logic [15:0] l1,
                            input logic [15:0] l2, input logic [31:0] dbase, input bit bp);
        int  n, sent, idx, stall, cyc;
        bit  fin, hs_last;
        n = exp_q.size();
        sent = 0; idx = 0; stall = 0; cyc = 0; fin = 0; hs_last = 0;
        @(posedge clk); #1;
        cfg_mode = mode; cfg_datasize = ds; cfg_start_addr = sa;
        cfg_len0 = l0; cfg_len1 = l1; cfg_len2 = l2;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        // configuration must already be latched
        cfg_mode = ~mode; cfg_datasize = 2'b11; cfg_start_addr = 15'h5555;
        cfg_len0 = 16'd7; cfg_len1 = 16'd7; cfg_len2 = 16'h0100;
        while (!fin && cyc < 100) begin
            stream_valid = (sent < n);
            stream_data  = dbase + 32'(sent);
            rx_ready     = 1'b1;
            cmd_start    = 1'b0;
            if (bp && rx_valid && idx == 1 && stall < 3) begin
                rx_ready = 1'b0;
                if (stall == 0) cmd_start = 1'b1;
            end
            #1;
            chk({name, "_done_low"}, 32'(cmd_done), 32'd0);
            if (!rx_ready) begin
                chk({name, "_stall_ready"}, 32'(stream_ready), 32'd0);
                chk({name, "_stall_addr"}, 32'(rx_addr), 32'(exp_q[1]));
                chk({name, "_stall_data"}, rx_data, dbase + 32'd1);
                stall++;
            end
            if (stream_valid && stream_ready) sent++;
            if (rx_valid && rx_ready) begin
                chk({name, "_addr"}, 32'(rx_addr), 32'(exp_q[idx]));
                chk({name, "_data"}, rx_data, dbase + 32'(idx));
                chk({name, "_dsize"}, 32'(rx_dsize), 32'(ds));
                idx++;
                hs_last = (idx == n);
            end
            @(posedge clk); #1;
            cmd_start = 1'b0;
            if (hs_last) begin
                chk({name, "_done_pulse"}, 32'(cmd_done), 32'd1);
                chk({name, "_done_ready"}, 32'(stream_ready), 32'd0);
                chk({name, "_done_valid"}, 32'(rx_valid), 32'd0);
                fin = 1;
            end
            cyc++;
        end
        if (!fin) chk({name, "_timeout"}, 32'd0, 32'd1);
        chk({name, "_beats"}, 32'(idx), 32'(n));
        stream_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, "_done_cleared"}, 32'(cmd_done), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; stream_data = '0; stream_valid = 1'b0; rx_ready = 1'b1;
        cmd_start = 1'b0; cfg_start_addr = '0; cfg_datasize = '0; cfg_mode = '0;
        cfg_len0 = '0; cfg_len1 = '0; cfg_len2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(stream_ready), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_addr", 32'(rx_addr), 32'd0);
        chk("rst_data", rx_data, 32'd0);
        chk("rst_dsize", 32'(rx_dsize), 32'd0);
        chk("rst_done", 32'(cmd_done), 32'd0);
        rst_i = 1'b0;

        exp_q = '{15'h100, 15'h104, 15'h108, 15'h10C};
        run_xfer("linear", 2'd0, 2'b10, 15'h100, 16'd3, 16'd0, 16'd0, 32'hA0, 1'b0);

        exp_q = '{15'h000, 15'h001, 15'h002, 15'h001, 15'h002, 15'h003};
        run_xfer("sliding", 2'd1, 2'b00, 15'h000, 16'd2, 16'd1, 16'd0, 32'hB0, 1'b0);

        exp_q = '{15'h20, 15'h22, 15'h20, 15'h22, 15'h20, 15'h22};
        run_xfer("circular", 2'd2, 2'b01, 15'h020, 16'd1, 16'd2, 16'd0, 32'hD0, 1'b0);

        exp_q = '{15'h40, 15'h44, 15'h50, 15'h54};
        run_xfer("twod", 2'd3, 2'b10, 15'h040, 16'd1, 16'd1, 16'h0010, 32'hE0, 1'b0);

        exp_q = '{15'h100, 15'h104, 15'h108, 15'h10C};
        run_xfer("backpressure", 2'd0, 2'b10, 15'h100, 16'd3, 16'd0, 16'd0, 32'hA0, 1'b1);

        exp_q = '{15'h7FFE, 15'h0002};
        run_xfer("wrap", 2'd0, 2'b10, 15'h7FFE, 16'd1, 16'd0, 16'd0, 32'hF0, 1'b0);

        exp_q = '{15'h0040};
        run_xfer("single", 2'd0, 2'b00, 15'h0040, 16'd0, 16'd0, 16'd0, 32'h11, 1'b0);

        // reset after two of four beats have been written
        @(posedge clk); #1;
        cfg_mode = 2'd0; cfg_datasize = 2'b10; cfg_start_addr = 15'h200;
        cfg_len0 = 16'd3; cfg_len1 = 16'd0; cfg_len2 = 16'd0;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0; stream_valid = 1'b1; stream_data = 32'hC0; rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_addr0", 32'(rx_addr), 32'h200);
        stream_data = 32'hC1;
        @(posedge clk); #1;
        chk("mid_addr1", 32'(rx_addr), 32'h204);
        chk("mid_data1", rx_data, 32'hC1);
        rst_i = 1'b1; stream_data = 32'hC2;
        @(posedge clk); #1;
        rst_i = 1'b0; stream_valid = 1'b0;
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_addr", 32'(rx_addr), 32'd0);
        chk("mid_rst_data", rx_data, 32'd0);
        chk("mid_rst_dsize", 32'(rx_dsize), 32'd0);
        chk("mid_rst_ready", 32'(stream_ready), 32'd0);
        chk("mid_rst_done", 32'(cmd_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_done", 32'(cmd_done), 32'd0);
        end

        exp_q = '{15'h300, 15'h302, 15'h304};
        run_xfer("after_reset", 2'd0, 2'b01, 15'h300, 16'd2, 16'd0, 16'd0, 32'h70, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_filter_rx_datastore.md
# udma_filter_rx_datastore

Write-side counterpart of the filter's TX data fetcher. It accepts a processed data stream from the uDMA filter datapath and writes each beat to L2 through a uDMA RX channel. It generates destination addresses in linear, sliding, circular or 2D patterns, and signals completion once the final beat has been accepted by the RX channel.

## Interface
Parameters:
- DATA_WIDTH, 32, stream and RX channel data width
- L2_AWIDTH_NOAL, 15, L2 byte address width
- TRANS_SIZE, 16, width of length/stride config fields

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- stream_data_i  in  DATA_WIDTH  incoming beat data
- stream_valid_i  in  1  beat valid
- stream_ready_o  out  1  beat accepted when valid & ready
- rx_ch_valid_o  out  1  write request to RX channel
- rx_ch_addr_o  out  L2_AWIDTH_NOAL  destination byte address
- rx_ch_datasize_o  out  2  latched datasize (00 byte, 01 half, 10 word)
- rx_ch_data_o  out  DATA_WIDTH  write data
- rx_ch_ready_i  in  1  RX channel accepts beat
- cmd_start_i  in  1  start transfer (honoured only in IDLE)
- cmd_done_o  out  1  one-cycle pulse, transfer complete
- cfg_start_addr_i  in  L2_AWIDTH_NOAL  base address
- cfg_datasize_i  in  2  element size
- cfg_mode_i  in  2  0 linear, 1 sliding, 2 circular, 3 2D
- cfg_len0_i  in  TRANS_SIZE  beats per line minus 1
- cfg_len1_i  in  TRANS_SIZE  lines minus 1 (modes 1-3)
- cfg_len2_i  in  TRANS_SIZE  2D line stride in bytes

## Operation
- FSM states: IDLE, RUNNING, DRAIN.
- IDLE -> RUNNING on cmd_start_i. The start cycle latches mode, datasize, len0/1/2 and start_addr into both startaddr and pointer registers, and clears counters w and l. Later cfg changes have no effect until the next start.
- RUNNING: each stream handshake captures data into a single output register. The capture sets rx_ch_valid_o with address = current pointer. The pointer and counters then update:
  - linear: pointer += inc; w++.
  - sliding: at w==len0, startaddr += inc, pointer = new startaddr, w=0, l++. Otherwise pointer += inc, w++.
  - circular: at w==len0, pointer = startaddr, w=0, l++. Otherwise pointer += inc, w++.
  - 2D: at w==len0, startaddr += len2, pointer = new startaddr, w=0, l++. Otherwise pointer += inc, w++.
- inc is 1/2/4 for datasize 00/01/10, and 0 for 11.
- Last beat: w==len0 in linear mode; w==len0 and l==len1 in the other modes. Capturing the last beat moves RUNNING -> DRAIN and forces stream_ready_o low.
- DRAIN -> IDLE when the RX handshake on the last beat occurs. cmd_done_o pulses in the following cycle.
- Address arithmetic is modulo 2^L2_AWIDTH_NOAL; carries are discarded. len2 is zero-extended or truncated to the address width.
- Data passes through unmodified. stream_datasize_i is not part of this block; the latched datasize drives rx_ch_datasize_o.
- cmd_start_i outside IDLE is ignored.

## Timing
- Reset values: stream_ready_o=0, rx_ch_valid_o=0, rx_ch_addr_o=0, rx_ch_data_o=0, rx_ch_datasize_o=0, cmd_done_o=0. The FSM resets to IDLE with all counters and pointers cleared.
- stream_ready_o = RUNNING & (!rx_ch_valid_o | rx_ch_ready_i). It is combinational from rx_ch_ready_i, so a full-throughput stream sustains one beat per cycle.
- Latency: a stream handshake in cycle t gives rx_ch_valid_o in cycle t+1.
- While rx_ch_valid_o=1 & rx_ch_ready_i=0:
  - data, address and datasize hold stable;
  - stream_ready_o=0.
- RX handshake with no new capture clears rx_ch_valid_o in the next cycle.
- cmd_done_o is registered. If the last RX handshake occurs in cycle t:
  - cmd_done_o=1 in cycle t+1, with state already IDLE;
  - cmd_start_i in t+1 is accepted;
  - stream_ready_o is high again from cycle t+2.
- Single-beat transfer (linear, len0=0): one capture, DRAIN, done.
- rst_i mid-transfer takes effect at the next edge:
  - rx_ch_valid_o drops;
  - FSM goes to IDLE;
  - no cmd_done_o pulse.

## Test plan
- Linear: start 0x100, datasize 10, len0=3, data 0xA0..0xA3 with ready always high -> addresses 0x100, 0x104, 0x108, 0x10C in consecutive cycles; cmd_done_o one cycle after the 4th handshake.
- Sliding: start 0x000, datasize 00, len0=2, len1=1 -> addresses 0,1,2,1,2,3; then done.
- Circular and 2D:
  - circular, start 0x20, datasize 01, len0=1, len1=2 -> 0x20, 0x22 repeated 3 times;
  - 2D, start 0x40, datasize 10, len0=1, len1=1, len2=0x10 -> 0x40, 0x44, 0x50, 0x54.
- Backpressure: hold rx_ch_ready_i low 3 cycles on beat 2 -> beat 2 address and data stable, stream_ready_o=0 throughout, no beat lost or duplicated. A cmd_start_i pulse during the transfer is ignored.
- Wrap: L2_AWIDTH_NOAL=15, start 0x7FFE, datasize 10, len0=1 -> addresses 0x7FFE, 0x0002.
- Reset mid-operation: assert rst_i after 2 of 4 beats -> all outputs at reset values next cycle, no cmd_done_o. A fresh start afterwards runs cleanly from its new cfg_start_addr_i.
